elevator_nfloor_ctrl: RTL and testbench

//  N-floor elevator controller: parametrised successor of the 2-floor elevator FSM.

---
 rtl/elevator_nfloor_ctrl_if.sv | 22 ++
 rtl/elevator_nfloor_ctrl.sv | 155 +++++++++++++++
 tb/tb_elevator_nfloor_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_nfloor_ctrl_if.sv
// Call/status bundle between the call-button logic (master) and the elevator
// controller (slave).
interface elevator_nfloor_ctrl_if #(
    parameter int NB_FLOORS = 4
);
    logic [NB_FLOORS-1:0] call_i;
    logic [NB_FLOORS-1:0] floor_o;
    logic                 open_o;
    logic                 moving_o;
    logic                 dir_up_o;
    logic [NB_FLOORS-1:0] pending_o;

    modport master (
        output call_i,
        input  floor_o, open_o, moving_o, dir_up_o, pending_o
    );

    modport slave (
        input  call_i,
        output floor_o, open_o, moving_o, dir_up_o, pending_o
    );
endinterface

// File: rtl/elevator_nfloor_ctrl.sv
// N-floor SCAN elevator controller: latches floor calls, keeps sweeping while
// requests lie ahead, and times door and travel with one shared cycle timer.
module elevator_nfloor_ctrl #(
    parameter int NB_FLOORS   = 4,
    parameter int DOOR_CYCLES = 8,
    parameter int MOVE_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    elevator_nfloor_ctrl_if.slave bus
);
    localparam int MAX_CYCLES = (DOOR_CYCLES > MOVE_CYCLES) ? DOOR_CYCLES : MOVE_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0]        DOOR_LOAD    = TW'(DOOR_CYCLES);
    localparam logic [TW-1:0]        MOVE_LOAD    = TW'(MOVE_CYCLES);
    localparam logic [TW-1:0]        TIMER_ONE    = TW'(1);
    localparam logic [NB_FLOORS-1:0] FLOOR_BOTTOM = NB_FLOORS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_MOVE
    } state_e;

    state_e               state_q;
    logic [NB_FLOORS-1:0] floor_q;
    logic [NB_FLOORS-1:0] pending_q;
    logic [TW-1:0]        timer_q;
    logic                 dir_up_q;
    logic                 open_q;
    logic                 moving_q;

    logic [NB_FLOORS-1:0] below_mask;
    logic [NB_FLOORS-1:0] above_mask;
    logic [NB_FLOORS-1:0] ahead_mask;
    logic [NB_FLOORS-1:0] behind_mask;
    logic [NB_FLOORS-1:0] next_floor;
    logic [NB_FLOORS-1:0] latch_mask;
    logic [NB_FLOORS-1:0] clear_mask;
    logic [NB_FLOORS-1:0] pending_d;
    logic                 ahead;
    logic                 behind;
    logic                 here_pending;
    logic                 next_pending;
    logic                 here_call;
    logic                 timer_done;

    // Floor masks come straight from the one-hot position: everything below is (onehot - 1).
    always_comb begin
        below_mask   = floor_q - FLOOR_BOTTOM;
        above_mask   = ~(floor_q | below_mask);
        ahead_mask   = dir_up_q ? above_mask : below_mask;
        behind_mask  = dir_up_q ? below_mask : above_mask;
        ahead        = |(pending_q & ahead_mask);
        behind       = |(pending_q & behind_mask);
        here_pending = |(pending_q & floor_q);
        next_floor   = dir_up_q ? (floor_q << 1) : (floor_q >> 1);
        next_pending = |(pending_q & next_floor);
        here_call    = |(bus.call_i & floor_q);
        timer_done   = (timer_q <= TIMER_ONE);

        latch_mask = (state_q == S_OPEN) ? ~floor_q : '1;
        clear_mask = '0;
        if (state_q == S_IDLE && here_pending) begin
            clear_mask = floor_q;
        end else if (state_q == S_MOVE && timer_done && next_pending) begin
            clear_mask = next_floor;
        end
        // NOTE: a clear on the edge that opens the door beats a same-edge call for that floor.
        pending_d = (pending_q | (bus.call_i & latch_mask)) & ~clear_mask;
    end

    // NOTE: every state register uses non-blocking assignment so all branches see pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            floor_q   <= FLOOR_BOTTOM;
            pending_q <= '0;
            timer_q   <= '0;
            dir_up_q  <= 1'b1;
            open_q    <= 1'b0;
            moving_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                S_IDLE: begin
                    if (here_pending) begin
                        state_q <= S_OPEN;
                        open_q  <= 1'b1;
                        timer_q <= DOOR_LOAD;
                    end else if (ahead || behind) begin
                        state_q  <= S_MOVE;
                        moving_q <= 1'b1;
                        timer_q  <= MOVE_LOAD;
                        if (!ahead) begin
                            dir_up_q <= ~dir_up_q;
                        end
                    end
                end

                S_OPEN: begin
                    if (here_call) begin
                        timer_q <= DOOR_LOAD;
                    end else if (!timer_done) begin
                        timer_q <= timer_q - TIMER_ONE;
                    end else begin
                        open_q <= 1'b0;
                        if (ahead || behind) begin
                            state_q  <= S_MOVE;
                            moving_q <= 1'b1;
                            timer_q  <= MOVE_LOAD;
                            if (!ahead) begin
                                dir_up_q <= ~dir_up_q;
                            end
                        end else begin
                            state_q <= S_IDLE;
                            timer_q <= '0;
                        end
                    end
                end

                S_MOVE: begin
                    if (!timer_done) begin
                        timer_q <= timer_q - TIMER_ONE;
                    end else begin
                        // Arrival edge: only a call latched before this edge stops the cabin here.
                        floor_q <= next_floor;
                        if (next_pending) begin
                            state_q  <= S_OPEN;
                            moving_q <= 1'b0;
                            open_q   <= 1'b1;
                            timer_q  <= DOOR_LOAD;
                        end else begin
                            timer_q <= MOVE_LOAD;
                        end
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    open_q   <= 1'b0;
                    moving_q <= 1'b0;
                    timer_q  <= '0;
                end
            endcase
        end
    end

    assign bus.floor_o   = floor_q;
    assign bus.open_o    = open_q;
    assign bus.moving_o  = moving_q;
    assign bus.dir_up_o  = dir_up_q;
    assign bus.pending_o = pending_q;
endmodule

// File: tb/tb_elevator_nfloor_ctrl.sv
// Self-checking bench for elevator_nfloor_ctrl: directed vector table, corner-case
// sequences, and random calls against a floor-level behavioural model.
module tb_elevator_nfloor_ctrl;
    localparam int N    = 4;
    localparam int DOOR = 3;
    localparam int MOVE = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    elevator_nfloor_ctrl_if #(.NB_FLOORS(N)) bus ();

    elevator_nfloor_ctrl #(
        .NB_FLOORS  (N),
        .DOOR_CYCLES(DOOR),
        .MOVE_CYCLES(MOVE)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [N-1:0] fl, input logic op, input logic mv,
                                         input logic du, input logic [N-1:0] pd);
        return 32'({fl, op, mv, du, pd});
    endfunction

    function automatic logic [31:0] dut_outs();
        return pack(bus.floor_o, bus.open_o, bus.moving_o, bus.dir_up_o, bus.pending_o);
    endfunction

    function automatic int onehot_index(input logic [N-1:0] v);
        int idx = -1;
        for (int f = 0; f < N; f++) begin
            if (v[f]) idx = (idx == -1) ? f : -2;
        end
        return idx;
    endfunction

    // Behavioural model: floor number, remaining door / travel cycles, direction, call list.
    int           m_floor;
    bit           m_dir;
    int           m_door;
    int           m_travel;
    logic [N-1:0] m_pend;

    task automatic model_reset();
        m_floor  = 0;
        m_dir    = 1'b1;
        m_door   = 0;
        m_travel = 0;
        m_pend   = '0;
    endtask

    function automatic bit request_beyond(input logic [N-1:0] pend, input int floor, input bit up);
        for (int f = 0; f < N; f++) begin
            if (pend[f] && (up ? (f > floor) : (f < floor))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_depart(input logic [N-1:0] pend);
        if (request_beyond(pend, m_floor, m_dir)) begin
            m_travel = MOVE;
        end else if (request_beyond(pend, m_floor, !m_dir)) begin
            m_dir    = !m_dir;
            m_travel = MOVE;
        end
    endtask

    task automatic model_step(input logic [N-1:0] call);
        logic [N-1:0] seen;
        logic [N-1:0] nxt;
        int           opened_at;
        seen      = m_pend;
        nxt       = m_pend;
        opened_at = -1;
        for (int f = 0; f < N; f++) begin
            if (call[f] && !(m_door > 0 && f == m_floor)) nxt[f] = 1'b1;
        end
        if (m_door > 0) begin
            if (call[m_floor]) begin
                m_door = DOOR;
            end else begin
                m_door--;
                if (m_door == 0) model_depart(seen);
            end
        end else if (m_travel > 0) begin
            m_travel--;
            if (m_travel == 0) begin
                m_floor += m_dir ? 1 : -1;
                if (seen[m_floor]) begin
                    m_door    = DOOR;
                    opened_at = m_floor;
                end else begin
                    m_travel = MOVE;
                end
            end
        end else if (seen[m_floor]) begin
            m_door    = DOOR;
            opened_at = m_floor;
        end else begin
            model_depart(seen);
        end
        if (opened_at >= 0) nxt[opened_at] = 1'b0;
        m_pend = nxt;
    endtask

    function automatic logic [31:0] model_outs();
        logic [N-1:0] oh;
        oh = '0;
        oh[m_floor] = 1'b1;
        return pack(oh, m_door > 0, m_travel > 0, m_dir, m_pend);
    endfunction

    // Inputs change at the falling edge; outputs are read back at the next falling edge.
    task automatic cycle(input logic [N-1:0] call);
        bus.call_i = call;
        @(posedge clk_i);
        if (rst_i) model_reset();
        else model_step(call);
        @(negedge clk_i);
    endtask

    int order_floor[$];
    int order_cycle[$];
    int order_dir[$];

    task automatic count_opens(input int cycles);
        logic prev;
        order_floor.delete();
        order_cycle.delete();
        order_dir.delete();
        prev = bus.open_o;
        for (int c = 1; c <= cycles; c++) begin
            cycle('0);
            if (bus.open_o && !prev) begin
                order_floor.push_back(onehot_index(bus.floor_o));
                order_cycle.push_back(c);
                order_dir.push_back(int'(bus.dir_up_o));
            end
            prev = bus.open_o;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cycle('0);
        rst_i = 1'b0;
    endtask

    typedef struct packed {
        logic         rst;
        logic [N-1:0] call;
        logic [N-1:0] floor;
        logic         open_e;
        logic         moving;
        logic         dir_up;
        logic [N-1:0] pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [N-1:0] c, input logic [N-1:0] fl, input logic op,
                       input logic mv, input logic du, input logic [N-1:0] pd);
        vec_t v;
        v.rst = r; v.call = c; v.floor = fl; v.open_e = op; v.moving = mv; v.dir_up = du; v.pend = pd;
        vecs.push_back(v);
    endtask

    logic [N-1:0] rnd_held;
    logic [N-1:0] rnd_call;

    initial begin
        bus.call_i = '0;
        model_reset();
        @(negedge clk_i);

        // Idle after reset release
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle('0);
            check($sformatf("idle_after_reset_%0d", i), dut_outs(), pack(4'b0001, 0, 0, 1, 4'b0000));
        end

        // Door at floor 0: plain open, then reopen with a reload
        add(1, 4'b0000, 4'b0001, 0, 0, 1, 4'b0000);
        add(0, 4'b0001, 4'b0001, 0, 0, 1, 4'b0001);
        add(0, 4'b0000, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b0001, 0, 0, 1, 4'b0000);
        add(0, 4'b0001, 4'b0001, 0, 0, 1, 4'b0001);
        add(0, 4'b0000, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0001, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b0001, 0, 0, 1, 4'b0000);
        // Full sweep from floor 0 to floor 3
        add(0, 4'b1000, 4'b0001, 0, 0, 1, 4'b1000);
        add(0, 4'b0000, 4'b0001, 0, 1, 1, 4'b1000);
        add(0, 4'b0000, 4'b0001, 0, 1, 1, 4'b1000);
        add(0, 4'b0000, 4'b0010, 0, 1, 1, 4'b1000);
        add(0, 4'b0000, 4'b0010, 0, 1, 1, 4'b1000);
        add(0, 4'b0000, 4'b0100, 0, 1, 1, 4'b1000);
        add(0, 4'b0000, 4'b0100, 0, 1, 1, 4'b1000);
        add(0, 4'b0000, 4'b1000, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b1000, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b1000, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b1000, 0, 0, 1, 4'b0000);
        // Reverse from the top; arrival-edge call at floor 2 is latched, served on the way back
        add(0, 4'b0001, 4'b1000, 0, 0, 1, 4'b0001);
        add(0, 4'b0000, 4'b1000, 0, 1, 0, 4'b0001);
        add(0, 4'b0000, 4'b1000, 0, 1, 0, 4'b0001);
        add(0, 4'b0100, 4'b0100, 0, 1, 0, 4'b0101);
        add(0, 4'b0000, 4'b0100, 0, 1, 0, 4'b0101);
        add(0, 4'b0000, 4'b0010, 0, 1, 0, 4'b0101);
        add(0, 4'b0000, 4'b0010, 0, 1, 0, 4'b0101);
        add(0, 4'b0000, 4'b0001, 1, 0, 0, 4'b0100);
        add(0, 4'b0000, 4'b0001, 1, 0, 0, 4'b0100);
        add(0, 4'b0000, 4'b0001, 1, 0, 0, 4'b0100);
        add(0, 4'b0000, 4'b0001, 0, 1, 1, 4'b0100);
        add(0, 4'b0000, 4'b0001, 0, 1, 1, 4'b0100);
        add(0, 4'b0000, 4'b0010, 0, 1, 1, 4'b0100);
        add(0, 4'b0000, 4'b0010, 0, 1, 1, 4'b0100);
        add(0, 4'b0000, 4'b0100, 1, 0, 1, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_i = vecs[i].rst;
            cycle(vecs[i].call);
            check($sformatf("vec_%0d", i), dut_outs(),
                  pack(vecs[i].floor, vecs[i].open_e, vecs[i].moving, vecs[i].dir_up, vecs[i].pend));
        end
        rst_i = 1'b0;

        // Two intermediate stops, each served once
        do_reset();
        cycle(4'b0110);
        count_opens(25);
        check("two_stops_count", 32'(order_floor.size()), 32'd2);
        check("two_stops_first_floor", 32'(order_floor[0]), 32'd1);
        check("two_stops_first_cycle", 32'(order_cycle[0]), 32'd3);
        check("two_stops_second_floor", 32'(order_floor[1]), 32'd2);
        check("two_stops_second_cycle", 32'(order_cycle[1]), 32'd8);
        check("two_stops_final", dut_outs(), pack(4'b0100, 0, 0, 1, 4'b0000));

        // Calls on every floor at once: one sweep, each floor once
        do_reset();
        cycle(4'b1111);
        count_opens(25);
        check("all_floors_count", 32'(order_floor.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("all_floors_order_%0d", k), 32'(order_floor[k]), 32'(k));
            check($sformatf("all_floors_cycle_%0d", k), 32'(order_cycle[k]), 32'(1 + 5 * k));
        end

        // Door open at floor 2 going up with calls above and below
        do_reset();
        cycle(4'b0100);
        for (int i = 0; i < 5; i++) cycle('0);
        check("sweep_setup_open", dut_outs(), pack(4'b0100, 1, 0, 1, 4'b0000));
        cycle(4'b1001);
        check("sweep_setup_pending", dut_outs(), pack(4'b0100, 1, 0, 1, 4'b1001));
        count_opens(30);
        check("sweep_count", 32'(order_floor.size()), 32'd2);
        check("sweep_first_floor", 32'(order_floor[0]), 32'd3);
        check("sweep_first_dir", 32'(order_dir[0]), 32'd1);
        check("sweep_first_cycle", 32'(order_cycle[0]), 32'd4);
        check("sweep_second_floor", 32'(order_floor[1]), 32'd0);
        check("sweep_second_dir", 32'(order_dir[1]), 32'd0);
        check("sweep_second_cycle", 32'(order_cycle[1]), 32'd13);

        // Asynchronous reset while travelling between floors 1 and 2
        do_reset();
        cycle(4'b0100);
        for (int i = 0; i < 4; i++) cycle('0);
        check("midmove_before_reset", dut_outs(), pack(4'b0010, 0, 1, 1, 4'b0100));
        rst_i = 1'b1;
        #1;
        check("midmove_async_reset", dut_outs(), pack(4'b0001, 0, 0, 1, 4'b0000));
        cycle('0);
        rst_i = 1'b0;

        // Random calls (pulses plus held levels) and rare resets against the model
        do_reset();
        rnd_held = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) rnd_held = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rnd_call = rnd_held | (($urandom_range(0, 5) == 0) ? N'($urandom) : '0);
            if ($urandom_range(0, 799) == 0) begin
                rst_i = 1'b1;
                #1;
                check("rnd_async_reset", dut_outs(), pack(4'b0001, 0, 0, 1, 4'b0000));
            end
            cycle(rnd_call);
            check($sformatf("rnd_model_%0d", c), dut_outs(), model_outs());
            rst_i = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
